// File: rtl/seg7_scan_ctrl_if.sv
// Display bus between the clock/alarm counters and the 7-segment scan controller.
// Carries the packed BCD value, per-digit masks and the active-low pin drives.
interface seg7_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_suppress;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_start;

    // Source side: supplies the value to show, observes the pins
    modport master (
        output bcd, dp_mask, blink_mask, lz_suppress,
        input  seg, dp, an, frame_start
    );

    // Controller side
    modport slave (
        input  bcd, dp_mask, blink_mask, lz_suppress,
        output seg, dp, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with per-digit decimal
// points, leading-zero suppression, dead-time blanking between digits and a
// frame-coherent snapshot of the displayed value.
// Optional feature macro: SEG7_BLINK_EN enables per-digit blinking.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_CYCLES = 500_000,
    parameter int unsigned DEAD_CYCLES    = 1_000,
    parameter int unsigned BLINK_CYCLES   = 50_000_000
) (
    input  logic             CLK100MHZ,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    state_e                state_q, state_d;
    logic                  snap_c;

    logic [BCD_W-1:0]      sh_bcd_q;
    logic [NUM_DIGITS-1:0] sh_dp_q;
    logic                  sh_lz_q;

    logic [NUM_DIGITS-1:0] zero_above_c;
    logic [3:0]            digit_c;
    logic                  lz_blank_c;
    logic                  blink_blank_c;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_start_q;

    // Active-low segment pattern {a..g}; non-decimal codes render as a dash
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            default: pat = 7'b1111110;
        endcase
        return pat;
    endfunction

    // Slot counter, digit index and the BLANK/DRIVE phase of the coming cycle
    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        state_d = (cnt_d < CNT_DEAD) ? ST_BLANK : ST_DRIVE;
        snap_c  = (cnt_q == '0) && (idx_q == '0);
    end

    // zero_above_c[i]: shadow digit i and every more-significant digit are zero
    always_comb begin
        zero_above_c = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_above_c[i] = ((sh_bcd_q >> (4 * i)) == '0);
        end
    end

    assign digit_c    = sh_bcd_q[{idx_q, 2'b00} +: 4];
    assign lz_blank_c = sh_lz_q && (idx_q != '0) && zero_above_c[idx_q];

`ifdef SEG7_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] sh_blink_q;

    // Free-running blink half-period counter
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Blink state and the blink-mask shadow, captured with the rest of the frame
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sh_blink_q    <= '0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (snap_c) begin
                sh_blink_q <= bus.blink_mask;
            end
        end
    end

    assign blink_blank_c = blink_phase_q && sh_blink_q[idx_q];
`else
    logic blink_unused;
    assign blink_unused  = ^{bus.blink_mask, BLINK_CYCLES[0]};
    assign blink_blank_c = 1'b0;
`endif

    // Pin drive for the current slot; any blank condition turns the whole digit off
    always_comb begin
        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if ((state_q == ST_DRIVE) && !lz_blank_c && !blink_blank_c) begin
            an_d[idx_q] = 1'b0;
            seg_d       = decode(digit_c);
            dp_d        = ~sh_dp_q[idx_q];
        end
    end

    // Scan state, frame snapshot and registered pin outputs
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            state_q       <= ST_BLANK;
            sh_bcd_q      <= '0;
            sh_dp_q       <= '0;
            sh_lz_q       <= 1'b0;
            an_q          <= '1;
            seg_q         <= '1;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            if (snap_c) begin
                sh_bcd_q <= bus.bcd;
                sh_dp_q  <= bus.dp_mask;
                sh_lz_q  <= bus.lz_suppress;
            end
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= snap_c;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a cycle-level reference model derived from elapsed
// time since reset pushes the expected pin state for every clock edge into a
// queue; a monitor on the falling edge pops and compares it against the DUT.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;
    localparam int N = 4;
    localparam int R = 8;
    localparam int D = 2;
    localparam int B = 64;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic         fs;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS    (N),
        .REFRESH_CYCLES(R),
        .DEAD_CYCLES   (D),
        .BLINK_CYCLES  (B)
    ) dut (
        .CLK100MHZ(clk),
        .rst      (rst),
        .bus      (bus)
    );

    int   errors = 0;
    int   checks = 0;
    out_t exp_q[$];

    // Reference model state: cycles since reset release plus the frame snapshot
    int           m_t = 0;
    logic [15:0]  m_bcd = '0;
    logic [N-1:0] m_dp = '0;
    logic [N-1:0] m_blink = '0;
    logic         m_lz = 1'b0;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h01;
            1: return 7'h4F;
            2: return 7'h12;
            3: return 7'h06;
            4: return 7'h4C;
            5: return 7'h24;
            6: return 7'h20;
            7: return 7'h0F;
            8: return 7'h00;
            9: return 7'h04;
            default: return 7'h7E;
        endcase
    endfunction

    // Model: at each edge derive slot position from time, decide the pin state
    always @(posedge clk) begin
        out_t e;
        int   cnt;
        int   idx;
        int   digit;
        bit   blank;
        e = '0;
        if (rst) begin
            m_t     = 0;
            m_bcd   = '0;
            m_dp    = '0;
            m_blink = '0;
            m_lz    = 1'b0;
            e.an    = '1;
            e.seg   = 7'h7F;
            e.dp    = 1'b1;
            e.fs    = 1'b0;
        end else begin
            cnt  = m_t % R;
            idx  = (m_t / R) % N;
            e.fs = ((m_t % (N * R)) == 0);
            if (e.fs) begin
                m_bcd   = bus.bcd;
                m_dp    = bus.dp_mask;
                m_blink = bus.blink_mask;
                m_lz    = bus.lz_suppress;
            end
            digit = int'((m_bcd >> (4 * idx)) & 16'hF);
            blank = (cnt < D);
            if (m_lz && idx != 0 && (m_bcd >> (4 * idx)) == 16'h0) blank = 1'b1;
`ifdef SEG7_BLINK_EN
            if (((m_t / B) % 2) == 1 && m_blink[idx]) blank = 1'b1;
`endif
            if (blank) begin
                e.an  = '1;
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end else begin
                e.an  = ~(N'(1) << idx);
                e.seg = seg_of(digit);
                e.dp  = ~m_dp[idx];
            end
            m_t = m_t + 1;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare DUT pins with the oldest expected entry, away from the edge
    always @(negedge clk) begin
        out_t e;
        out_t g;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {bus.an, bus.seg, bus.dp, bus.frame_start};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL pins @%0t t=%0d: got an=%b seg=%b dp=%b fs=%b, expected an=%b seg=%b dp=%b fs=%b",
                         $time, m_t, g.an, g.seg, g.dp, g.fs, e.an, e.seg, e.dp, e.fs);
            end
            checks++;
            if ($countones(~bus.an) > 1) begin
                errors++;
                $display("FAIL one_hot_an @%0t: got an=%b, required at most one low bit", $time, bus.an);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait until the next edge lands on the given slot position
    task automatic wait_slot(input int cnt, input int idx);
        int k;
        k = 0;
        while (!((m_t % R) == cnt && ((m_t / R) % N) == idx) && k < 4 * N * R) begin
            cyc(1);
            k++;
        end
        checks++;
        if (k >= 4 * N * R) begin
            errors++;
            $display("FAIL wait_slot: got no cnt=%0d idx=%0d within %0d cycles, required reached", cnt, idx, k);
        end
    endtask

    initial begin
        bus.bcd         = 16'h1234;
        bus.dp_mask     = '0;
        bus.blink_mask  = '0;
        bus.lz_suppress = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(70);

        // Change value mid-frame while digit 2 is scanned
        wait_slot(0, 2);
        bus.bcd = 16'h5678;
        cyc(80);

        // Leading-zero suppression
        bus.bcd         = 16'h0005;
        bus.lz_suppress = 1'b1;
        cyc(40);
        bus.bcd = 16'h0000;
        cyc(40);
        bus.lz_suppress = 1'b0;
        cyc(40);

        // Blinking of the two low digits
        bus.bcd        = 16'h1234;
        bus.blink_mask = 4'b0011;
        cyc(300);
        bus.blink_mask = '0;

        // Invalid code and decimal point
        bus.bcd     = 16'h00F0;
        bus.dp_mask = 4'b0100;
        cyc(40);

        // Reset in the middle of digit 2's drive phase
        wait_slot(5, 2);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(40);

        // Random values, masks and occasional resets
        repeat (30) begin
            bus.bcd         = 16'($urandom);
            bus.dp_mask     = N'($urandom);
            bus.blink_mask  = N'($urandom);
            bus.lz_suppress = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                cyc($urandom_range(1, 3));
                rst = 1'b0;
            end
            cyc($urandom_range(1, 60));
        end
        cyc(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
